// File: rtl/recibir_datos.sv
// rtl/recibir_datos.sv - 16x oversampled UART byte receiver with command decode.
// Define RX_PARITY_EN to add an even-parity bit between data and stop.
module recibir_datos #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t        state;
  logic          rx_s1, rx_s2;
  logic [DW-1:0] div_cnt;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    samp;
  logic [7:0]    shreg;
  logic [3:0]    brk_cnt;
  logic          tick;
  logic          maj;
  logic          at_9;
  logic          at_15;

  assign tick  = (state != IDLE) && (div_cnt == DW'(DIV - 1));
  assign at_9  = tick && (tick_cnt == 4'd9);
  assign at_15 = tick && (tick_cnt == 4'd15);
  // Majority vote of the samples taken at ticks 7 and 8 plus the live tick-9 sample.
  assign maj   = (samp[0] & samp[1]) | (samp[0] & rx_s2) | (samp[1] & rx_s2);

`ifdef RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      state      <= IDLE;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      samp       <= '0;
      shreg      <= '0;
      brk_cnt    <= '0;
      data       <= 8'h00;
      cmd        <= 3'd0;
      data_valid <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      data_valid <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;

      if (tick) begin
        tick_cnt <= tick_cnt + 1'b1;
        if (tick_cnt == 4'd7) samp[0] <= rx_s2;
        if (tick_cnt == 4'd8) samp[1] <= rx_s2;
      end

      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s2) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (at_9 && maj) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (at_15) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (at_9) shreg <= {maj, shreg[7:1]};
          if (at_15) begin
            bit_cnt <= bit_cnt + 1'b1;
`ifdef RX_PARITY_EN
            if (bit_cnt == 3'd7) state <= PARITY;
`else
            if (bit_cnt == 3'd7) state <= STOP;
`endif
          end
        end
`ifdef RX_PARITY_EN
        PARITY: begin
          if (at_9)  par_bad <= maj ^ (^shreg);
          if (at_15) state <= STOP;
        end
`endif
        STOP: begin
          // Decide mid stop bit so a back-to-back start edge is not missed.
          if (at_9) begin
            if (maj) begin
`ifdef RX_PARITY_EN
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
`else
              begin
`endif
                data       <= shreg;
                data_valid <= 1'b1;
                if (shreg[7:3] == 5'd0) begin
                  cmd       <= shreg[2:0];
                  cmd_valid <= 1'b1;
                end
              end
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              brk_cnt   <= '0;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (!rx_s2) begin
            brk_cnt <= '0;
          end else if (tick) begin
            if (brk_cnt == 4'd15) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              brk_cnt <= brk_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recibir_datos.sv
// tb/tb_recibir_datos.sv - directed frame bench for recibir_datos (DIV=10, 160 clocks/bit).
// Exercises the RX_PARITY_EN build too when the macro is defined.
module tb_recibir_datos;

  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int dv_tot = 0, cv_tot = 0, fe_tot = 0, pe_tot = 0;
  logic [7:0] dv_log[$];
  logic [2:0] cmd_log[$];
  int dv0, cv0, fe0, pe0;

  recibir_datos #(.CLK_HZ(1600000), .BAUD(10000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .data_valid(data_valid),
    .cmd(cmd), .cmd_valid(cmd_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_tot++;
      dv_log.push_back(data);
      cmd_log.push_back(cmd);
    end
    if (cmd_valid)  cv_tot++;
    if (frame_err)  fe_tot++;
    if (parity_err) pe_tot++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    dv0 = dv_tot; cv0 = cv_tot; fe0 = fe_tot; pe0 = pe_tot;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_flip);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT_CLKS);
    end
`ifdef RX_PARITY_EN
    rx = (^b) ^ par_flip;
    wait_clks(BIT_CLKS);
`endif
    rx = stop_ok;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
  endtask

  initial begin
    int base;
    wait_clks(3);
    chk("rst_data", data, 8'h00);
    chk("rst_cmd", cmd, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dv", data_valid, 1'b0);
    rst = 1'b0;
    wait_clks(20);

    // Single command byte
    snap(); base = dv_tot;
    send_frame(8'h05, 1'b1, 1'b0);
    wait_clks(50);
    chk("f05_dv_cnt", dv_tot - dv0, 1);
    chk("f05_data", data, 8'h05);
    chk("f05_cmd", cmd, 3'd5);
    chk("f05_cv_cnt", cv_tot - cv0, 1);
    chk("f05_busy", busy, 1'b0);

    // Back-to-back: non-command then command
    snap(); base = dv_tot;
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0);
    wait_clks(50);
    chk("b2b_dv_cnt", dv_tot - dv0, 2);
    if (dv_tot - dv0 == 2) begin
      chk("b2b_byte0", dv_log[base], 8'hA3);
      chk("b2b_cmd_after_a3", cmd_log[base], 3'd5);
      chk("b2b_byte1", dv_log[base+1], 8'h01);
    end
    chk("b2b_cv_cnt", cv_tot - cv0, 1);
    chk("b2b_cmd", cmd, 3'd1);

    // Glitch shorter than half a bit is a false start
    snap();
    rx = 1'b0;
    wait_clks(60);
    rx = 1'b1;
    wait_clks(200);
    chk("glitch_pulses", (dv_tot - dv0) + (cv_tot - cv0) + (fe_tot - fe0), 0);
    chk("glitch_busy", busy, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    wait_clks(50);
    chk("glitch_next_data", data, 8'h02);
    chk("glitch_next_cmd", cmd, 3'd2);
    chk("glitch_next_dv", dv_tot - dv0, 1);

    // Framing error followed by a long break
    snap();
    send_frame(8'h7E, 1'b0, 1'b0);
    rx = 1'b0;
    wait_clks(2000);
    rx = 1'b1;
    wait_clks(300);
    chk("brk_fe_cnt", fe_tot - fe0, 1);
    chk("brk_dv_cnt", dv_tot - dv0, 0);
    chk("brk_data", data, 8'h02);
    chk("brk_busy", busy, 1'b0);
    send_frame(8'h04, 1'b1, 1'b0);
    wait_clks(50);
    chk("brk_next_data", data, 8'h04);
    chk("brk_next_cmd", cmd, 3'd4);

    // Reset in the middle of a frame
    snap();
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        wait_clks(BIT_CLKS * 5 + 80);
        rst = 1'b1;
        wait_clks(2);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_data", data, 8'h00);
      end
    join
    wait_clks(20);
    rst = 1'b0;
    wait_clks(20);
    base = dv_tot;
    send_frame(8'h33, 1'b1, 1'b0);
    wait_clks(50);
    chk("rst_dv_cnt", dv_tot - dv0, 1);
    chk("rst_data_33", data, 8'h33);
    chk("rst_cmd_kept", cmd, 3'd0);
    chk("rst_cv_cnt", cv_tot - cv0, 0);

`ifdef RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clks(50);
    chk("par_pe_cnt", pe_tot - pe0, 1);
    chk("par_dv_cnt", dv_tot - dv0, 0);
    chk("par_cmd", cmd, 3'd0);
    chk("par_data", data, 8'h33);
`else
    chk("no_parity_err", pe_tot, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50ms;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/recibir_datos.md
RECIBIR_DATOS -- requirements
Module: recibir_datos

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning serial line bit rate.
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port rx  input  1  asynchronous serial line, idle high; this is the line driven by the transmit mux.
REQ-006 The block SHALL have port data  output  8  last received byte.
REQ-007 The block SHALL have port data_valid  output  1  one-cycle pulse when a good byte is in data.
REQ-008 The block SHALL have port cmd  output  3  command code, equal to data[2:0] of the last command byte.
REQ-009 The block SHALL have port cmd_valid  output  1  one-cycle pulse when a good byte with data[7:3]==0 is received.
REQ-010 The block SHALL have port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-011 The block SHALL have port parity_err  output  1  one-cycle pulse when a parity mismatch is detected.
REQ-012 The block SHALL have port busy  output  1  high whenever the state machine is not IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (flops reset to 1) before any use; the synchronizer delay SHALL be excluded from all latencies below.
REQ-014 A tick SHALL occur every DIV = CLK_HZ/(BAUD*16) clocks (integer division); the divider counter SHALL be reset to 0 in IDLE; each bit SHALL last 16 ticks.
REQ-015 Each bit value SHALL be the majority of the samples at ticks 7, 8 and 9 of that bit; a bit decision SHALL be made at tick 9.
REQ-016 States SHALL be IDLE, START, DATA, PARITY (only with RX_PARITY_EN), STOP and BREAK.
REQ-017 IDLE->START SHALL occur on the first clock with synchronized rx==0.
REQ-018 In START, a majority-high start bit SHALL be a false start: return to IDLE with no output pulse.
REQ-019 DATA SHALL shift in 8 bits LSB first, with a 3-bit bit counter wrapping 7->0; at wrap the next state SHALL be PARITY or STOP.
REQ-020 STOP majority-high SHALL update data and pulse data_valid on the next clock, and update cmd and pulse cmd_valid when data[7:3]==0; the state SHALL then return to IDLE.
REQ-021 A good byte with data[7:3]!=0 SHALL update data and pulse data_valid only; cmd SHALL be unchanged.
REQ-022 STOP majority-low SHALL pulse frame_err, SHALL leave data and cmd unchanged, and SHALL enter BREAK.
REQ-023 BREAK SHALL wait for synchronized rx==1 for 16 consecutive ticks before IDLE, so that a held-low line yields exactly one frame_err.
REQ-024 data_valid, cmd_valid, frame_err and parity_err SHALL never be high for more than one clock per frame.
REQ-025 A start edge arriving in the same clock as the return to IDLE SHALL be accepted on the following clock; back-to-back frames with one stop bit SHALL be received without loss.

Reset
REQ-026 While rst is high: state IDLE; data=8'h00; cmd=3'd0; all pulses, busy and counters 0; synchronizer flops 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception SHALL resume at the next falling edge of rx.

Configuration
REQ-028 Macro RX_PARITY_EN defined: an even-parity bit SHALL follow the data bits and be sampled in PARITY per REQ-015.
REQ-029 With RX_PARITY_EN, a mismatch SHALL pulse parity_err in the data_valid slot, with no data_valid or cmd_valid pulse and no data or cmd update; STOP SHALL still be checked.
REQ-030 Macro RX_PARITY_EN undefined: the PARITY state SHALL be absent and parity_err SHALL be tied 0.

Verification (bench CLK_HZ=1600000, BAUD=10000, DIV=10, 160 clocks/bit)
REQ-031 Frame 0x05 -> data=0x05, one data_valid pulse, cmd=3'd5, one cmd_valid pulse, busy low afterwards.
REQ-032 Frame 0xA3 followed back-to-back by 0x01 -> data_valid pulses for 0xA3 then 0x01; cmd_valid only for 0x01 with cmd=1.
REQ-033 rx low for 60 clocks then high -> no pulses, return to IDLE, next frame 0x02 received correctly.
REQ-034 Frame 0x7E with stop bit low and line held low for 2000 clocks -> exactly one frame_err, data unchanged, next frame received after release.
REQ-035 rst asserted at bit 4 of frame 0x55, released, then frame 0x33 sent -> only 0x33 reported.
REQ-036 RX_PARITY_EN defined: frame 0x07 sent with parity=0 -> parity_err pulse, no data_valid, cmd unchanged.
